// File: rtl/data_memory.sv
// Line-granular main-memory model below the data cache: one read or write at a
// time, acknowledged a fixed LATENCY cycles after acceptance.
module data_memory #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned WIDTH   = 256,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [WIDTH-1:0]  data_o
);

    localparam int unsigned OFF_W = $clog2(WIDTH / 8);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [IDX_W-1:0]   line_idx;

    // Storage array; name is fixed for hierarchical preload/flush by benches.
    logic [WIDTH-1:0]   memory [0:DEPTH-1];

    // Offset bits and upper bits do not select a line; addresses alias modulo the array size.
    logic unused_addr_c;
    assign unused_addr_c = ^{addr_i[ADDR_W-1:OFF_W+IDX_W], addr_i[OFF_W-1:0]};

    assign line_idx = addr_i[OFF_W +: IDX_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_q <= WAIT;
                        count_q <= CNT_W'(1);
                    end else begin
                        count_q <= '0;
                    end
                end
                WAIT: begin
                    if (count_q == CNT_W'(LATENCY)) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    // Ack decodes registered state only, so it is a clean single-cycle pulse.
    assign ack_o  = (state_q == WAIT) && (count_q == CNT_W'(LATENCY));
    assign data_o = ack_o ? memory[line_idx] : '0;

    // The write commits on the edge that closes the ack cycle; reset drops it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && ack_o && write_i) begin
            memory[line_idx] <= data_i;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: requests push expected acks, a negedge
// monitor pops them and checks data and latency.
module tb_data_memory;

    localparam int unsigned LAT    = 10;
    localparam int unsigned DEPTH  = 512;
    localparam int unsigned WIDTH  = 256;
    localparam int unsigned ADDR_W = 32;

    typedef struct {
        bit               rd;
        logic [WIDTH-1:0] data;
        int               start;
    } item_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              enable;
    logic              write;
    logic              ack;
    logic [WIDTH-1:0]  rdata;

    item_t             sb[$];
    int                ack_cyc[$];
    logic [WIDTH-1:0]  model [0:DEPTH-1];
    int                cyc   = 0;
    int                total = 0;
    int                bad   = 0;

    data_memory #(
        .LATENCY (LAT),
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (addr),
        .data_i   (wdata),
        .enable_i (enable),
        .write_i  (write),
        .ack_o    (ack),
        .data_o   (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int line_of(input logic [ADDR_W-1:0] a);
        return int'(a[13:5]);
    endfunction

    // Monitor: every ack must match the oldest outstanding request.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            ack_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("spurious_ack", 1, 0);
            end else begin
                item_t it;
                it = sb.pop_front();
                chk("latency", WIDTH'(cyc - it.start), WIDTH'(LAT));
                if (it.rd) chk("read_data", rdata, it.data);
            end
        end else begin
            chk("data_idle", rdata, '0);
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic req(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d, input bit wr, input bit keep);
        item_t it;
        bit    seen;
        addr   = a;
        wdata  = d;
        write  = wr;
        enable = 1'b1;
        it.rd    = !wr;
        it.data  = model[line_of(a)];
        it.start = cyc;
        sb.push_back(it);
        if (wr) model[line_of(a)] = d;
        seen = 1'b0;
        for (int i = 0; i < 4 * LAT && !seen; i++) begin
            @(negedge clk);
            if (ack === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("ack_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        if (!keep) enable = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        write  = 1'b0;
        addr   = '0;
        wdata  = '0;
        dut.memory[0] = 256'h5;
        dut.memory[2] = 256'hBB;
        model[0] = 256'h5;
        model[2] = 256'hBB;
        repeat (3) @(negedge clk);
        chk("rst_ack", WIDTH'(ack), 0);
        chk("rst_data", rdata, '0);
        rst = 1'b0;
        @(negedge clk);

        // Preload and read
        req(32'h0000, '0, 1'b0, 1'b0);

        // Write then read
        req(32'h0020, 256'hDEADBEEF, 1'b1, 1'b0);
        chk("mem1_after_write", dut.memory[1], 256'hDEADBEEF);
        req(32'h0020, '0, 1'b0, 1'b0);

        // Aliasing and ignored offset bits
        req(32'h4000, 256'hA5, 1'b1, 1'b0);
        req(32'h0000, '0, 1'b0, 1'b0);
        req(32'h001F, '0, 1'b0, 1'b0);

        // Enable held high across back-to-back reads
        req(32'h0020, '0, 1'b0, 1'b1);
        req(32'h0000, '0, 1'b0, 1'b1);
        req(32'h0020, '0, 1'b0, 1'b0);
        chk("ack_gap_a", WIDTH'(ack_cyc[ack_cyc.size()-2] - ack_cyc[ack_cyc.size()-3]), WIDTH'(LAT + 1));
        chk("ack_gap_b", WIDTH'(ack_cyc[ack_cyc.size()-1] - ack_cyc[ack_cyc.size()-2]), WIDTH'(LAT + 1));

        // Reset mid-transaction: write abandoned, no ack
        addr   = 32'h0040;
        wdata  = 256'h1;
        write  = 1'b1;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ack", WIDTH'(ack), 0);
        rst    = 1'b0;
        enable = 1'b0;
        write  = 1'b0;
        repeat (2 * LAT) @(negedge clk);
        chk("midrst_mem2", dut.memory[2], model[2]);
        req(32'h0040, '0, 1'b0, 1'b0);

        // Reset held high masks enable
        rst    = 1'b1;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("rsthold_ack", WIDTH'(ack), 0);
        rst    = 1'b0;
        enable = 1'b0;
        repeat (2 * LAT) @(negedge clk);

        // Reset does not clear storage
        dut.memory[32] = 256'h7;
        model[32]      = 256'h7;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req(32'h0400, '0, 1'b0, 1'b0);

        // Top line, written and read through an aliased address
        req(32'h3FE0, {8{32'hCAFE_F00D}}, 1'b1, 1'b0);
        req(32'h7FFF, '0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", WIDTH'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/data_memory.md
# data_memory

Behavioural main-memory model sitting below the CPU's data cache on the 256-bit line bus. It stores 512 lines of 256 bits (16 KB), accepts one line read or line write at a time via an enable/ack handshake, and answers after a fixed multi-cycle latency. The storage array is hierarchically accessible, so benches can preload it and flush cache lines into it directly.

## Interface
- LATENCY, 10: cycles from request acceptance to the ack cycle; legal range 2–15.
- DEPTH, 512: number of lines.
- WIDTH, 256: line width in bits.
- ADDR_W, 32: byte-address width.
- clk_i  input  1  single clock; everything is updated on its rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- addr_i  input  ADDR_W  byte address; line index = addr_i[13:5]; bits [4:0] and [31:14] are ignored.
- data_i  input  WIDTH  write line.
- enable_i  input  1  request valid.
- write_i  input  1  1 = write, 0 = read; qualified by enable_i.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  WIDTH  read line; valid only while ack_o=1.
- Storage is the array `memory[0:DEPTH-1]` of WIDTH bits. Its name is fixed so benches can access it hierarchically.

## Operation
- FSM has two states, IDLE and WAIT, plus a cycle counter `count` of 4 bits.
- **IDLE, enable_i=1 at an edge:** go to WAIT with count=1.
- **IDLE, enable_i=0:** stay in IDLE with count=0.
- **WAIT, count<LATENCY:** count increments by 1 each edge.
- **WAIT, count==LATENCY:** this is the ack cycle; the next edge returns to IDLE with count=0.
- ack_o = (state==WAIT && count==LATENCY). It is combinational from registered state, so it is glitch-free and exactly one cycle wide.
- **Read:** during the ack cycle, data_o = memory[addr_i[13:5]]. At all other times data_o = 0.
- **Write:** memory[addr_i[13:5]] <= data_i on the edge that ends the ack cycle. No other cycle writes the array.
- The requester holds addr_i, data_i, write_i and enable_i stable from the request cycle through the ack cycle. Values are sampled in the ack cycle.
- enable_i is ignored while in WAIT. A second request is only accepted in IDLE, so the earliest new request is accepted the cycle after ack.
- If enable_i is still high in the IDLE cycle after ack, it is treated as a new request.
- Addresses alias modulo 16 KB: 0x4000 maps to line 0. There is no error response.

## Timing
- Request accepted at edge E0, where enable_i=1 and state is IDLE. ack_o is high in the cycle after edge E0+LATENCY-1, i.e. the LATENCY-th cycle after acceptance.
- Back-to-back request throughput is one transfer per LATENCY+1 cycles.
- Read data is visible combinationally in the ack cycle. Write data is visible to a read starting at the earliest next request.
- **Reset at an edge with rst_i=1:**
  - state=IDLE, count=0, ack_o=0, data_o=0.
  - An in-flight transaction is abandoned with no ack.
  - A pending write is dropped, i.e. no write occurs if reset is high in the ack cycle.
  - memory contents are NOT cleared, so preloaded data survives reset.
- Reset has priority over enable_i.
- With rst_i held high, enable_i is ignored.

## Test plan
- **Preload and read:** preload memory[0]=256'h5, release reset, read addr 0x0000 with enable high at E0. Expect ack_o=1 only in the LATENCY-th cycle (10th), data_o=256'h5 in that cycle, and data_o=0 in every other cycle.
- **Write then read:** write 256'hDEADBEEF at addr 0x0020, then read 0x0020. Expect two acks, separated by ≥11 cycles, and the read returns 256'hDEADBEEF.
- **Aliasing and ignored offset bits:** write 256'hA5 at 0x4000, then read 0x0000. Expect 256'hA5. A read of 0x001F also returns line 0.
- **Enable held high:** two consecutive read requests with enable high continuously. Expect acks exactly 11 cycles apart, each one cycle wide.
- **Reset mid-transaction:** start a write of 256'h1 to 0x0040 and assert rst_i at cycle 5. Expect no ack, memory[2] unchanged, state IDLE, and the next request completing normally after LATENCY cycles.
- **Reset does not clear storage:** preload memory[32]=256'h7, pulse reset, read 0x0400. Expect 256'h7.
